// File: rtl/multicycle_control_pkg.sv
// rtl/multicycle_control_pkg.sv - shared states, opcode/funct and mux encodings
package ctrl_pkg;

   typedef enum logic [3:0] {
      FETCH, DECODE, MEMADDR, MEMREAD, MEMWB, MEMWRITE,
      RTYPE_EX, RTYPE_WB, BRANCH, ADDI_EX, ADDI_WB, JUMP, TRAP
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100011;
   localparam logic [5:0] OP_SW   = 6'b101011;
   localparam logic [5:0] OP_R    = 6'b000000;
   localparam logic [5:0] OP_BEQ  = 6'b000100;
   localparam logic [5:0] OP_ADDI = 6'b001000;
   localparam logic [5:0] OP_J    = 6'b000010;

   localparam logic [5:0] FN_ADD = 6'b100000;
   localparam logic [5:0] FN_SUB = 6'b100010;
   localparam logic [5:0] FN_AND = 6'b100100;
   localparam logic [5:0] FN_OR  = 6'b100101;
   localparam logic [5:0] FN_SLT = 6'b101010;

   localparam logic [2:0] ALU_AND = 3'd0;
   localparam logic [2:0] ALU_OR  = 3'd1;
   localparam logic [2:0] ALU_ADD = 3'd2;
   localparam logic [2:0] ALU_SUB = 3'd6;
   localparam logic [2:0] ALU_SLT = 3'd7;

   localparam logic [1:0] SRCB_B       = 2'd0;
   localparam logic [1:0] SRCB_FOUR    = 2'd1;
   localparam logic [1:0] SRCB_IMM     = 2'd2;
   localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - controller to datapath/memory signal bundle
interface multicycle_control_if #(
   parameter int INS_W = 32,
   parameter int ALU_W = 5,
   parameter int CNT_W = 32
);
   logic [INS_W-1:0] ins;
   logic             zero;
   logic             memReady;
   logic             pcWrite;
   logic             pcWriteCond;
   logic             iOrD;
   logic             memRead;
   logic             memWrite;
   logic             irWrite;
   logic             regWriteEnable;
   logic             regDst;
   logic             memToReg;
   logic             aluSrcA;
   logic [1:0]       aluSrcB;
   logic [ALU_W-1:0] aluCtl;
   logic [1:0]       pcSource;
   logic             trap;
   logic [CNT_W-1:0] retired;

   modport master (
      input  ins, zero, memReady,
      output pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite,
             regWriteEnable, regDst, memToReg, aluSrcA, aluSrcB, aluCtl,
             pcSource, trap, retired
   );

   modport slave (
      output ins, zero, memReady,
      input  pcWrite, pcWriteCond, iOrD, memRead, memWrite, irWrite,
             regWriteEnable, regDst, memToReg, aluSrcA, aluSrcB, aluCtl,
             pcSource, trap, retired
   );
endinterface

// File: rtl/multicycle_control_alu_decoder.sv
// rtl/multicycle_control_alu_decoder.sv - R-type funct to ALU control with illegal flag
module alu_decoder
   import ctrl_pkg::*;
#(
   parameter int ALU_W = 5
) (
   input  logic [5:0]       funct,
   output logic [ALU_W-1:0] aluCtl,
   output logic             illegal
);

   always_comb begin
      aluCtl  = ALU_W'(ALU_ADD);
      illegal = 1'b0;
      case (funct)
         FN_ADD:  aluCtl = ALU_W'(ALU_ADD);
         FN_SUB:  aluCtl = ALU_W'(ALU_SUB);
         FN_AND:  aluCtl = ALU_W'(ALU_AND);
         FN_OR:   aluCtl = ALU_W'(ALU_OR);
         FN_SLT:  aluCtl = ALU_W'(ALU_SLT);
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle MIPS-subset control FSM with retire counter
module multicycle_control
   import ctrl_pkg::*;
#(
   parameter int INS_W  = 32,
   parameter int ALU_W  = 5,
   parameter int CNT_W  = 32,
   parameter int MEM_HS = 1
) (
   input logic                 clk,
   input logic                 rst_n,
   multicycle_control_if.master bus
);

   state_t           state, state_nx;
   logic             rdy;
   logic             retire;
   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [ALU_W-1:0] fn_alu;
   logic             fn_illegal;
   logic [CNT_W-1:0] retired_q;
   logic             unused_bits;

   assign opcode      = bus.ins[INS_W-1 -: 6];
   assign funct       = bus.ins[5:0];
   assign rdy         = (MEM_HS != 0) ? bus.memReady : 1'b1;
   assign bus.retired = retired_q;
   // Fields consumed by the datapath only; kept here so every input is accounted for.
   assign unused_bits = ^{bus.zero, bus.ins[INS_W-7:6]};

   alu_decoder #(.ALU_W(ALU_W)) u_alu_dec (
      .funct   (funct),
      .aluCtl  (fn_alu),
      .illegal (fn_illegal)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= FETCH;
         retired_q <= '0;
      end else begin
         state <= state_nx;
         if (retire)
            retired_q <= retired_q + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx           = state;
      retire             = 1'b0;
      bus.pcWrite        = 1'b0;
      bus.pcWriteCond    = 1'b0;
      bus.iOrD           = 1'b0;
      bus.memRead        = 1'b0;
      bus.memWrite       = 1'b0;
      bus.irWrite        = 1'b0;
      bus.regWriteEnable = 1'b0;
      bus.regDst         = 1'b0;
      bus.memToReg       = 1'b0;
      bus.aluSrcA        = 1'b0;
      bus.aluSrcB        = SRCB_B;
      bus.aluCtl         = ALU_W'(ALU_ADD);
      bus.pcSource       = PCSRC_ALU;
      bus.trap           = 1'b0;
      case (state)
         FETCH: begin
            bus.memRead = 1'b1;
            bus.aluSrcB = SRCB_FOUR;
            // PC and IR load only on the ready cycle so PC+4 happens exactly once.
            if (rdy) begin
               bus.irWrite = 1'b1;
               bus.pcWrite = 1'b1;
               state_nx    = DECODE;
            end
         end
         DECODE: begin
            bus.aluSrcB = SRCB_IMM_SH2;
            case (opcode)
               OP_LW, OP_SW: state_nx = MEMADDR;
               OP_R:         state_nx = RTYPE_EX;
               OP_BEQ:       state_nx = BRANCH;
               OP_ADDI:      state_nx = ADDI_EX;
               OP_J:         state_nx = JUMP;
               default:      state_nx = TRAP;
            endcase
         end
         MEMADDR: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = SRCB_IMM;
            state_nx    = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
         end
         MEMREAD: begin
            bus.memRead = 1'b1;
            bus.iOrD    = 1'b1;
            if (rdy)
               state_nx = MEMWB;
         end
         MEMWB: begin
            bus.regWriteEnable = 1'b1;
            bus.memToReg       = 1'b1;
            retire             = 1'b1;
            state_nx           = FETCH;
         end
         MEMWRITE: begin
            bus.memWrite = 1'b1;
            bus.iOrD     = 1'b1;
            if (rdy) begin
               retire   = 1'b1;
               state_nx = FETCH;
            end
         end
         RTYPE_EX: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = SRCB_B;
            bus.aluCtl  = fn_alu;
            state_nx    = fn_illegal ? TRAP : RTYPE_WB;
         end
         RTYPE_WB: begin
            bus.regWriteEnable = 1'b1;
            bus.regDst         = 1'b1;
            retire             = 1'b1;
            state_nx           = FETCH;
         end
         BRANCH: begin
            bus.aluSrcA     = 1'b1;
            bus.aluSrcB     = SRCB_B;
            bus.aluCtl      = ALU_W'(ALU_SUB);
            bus.pcWriteCond = 1'b1;
            bus.pcSource    = PCSRC_ALUOUT;
            retire          = 1'b1;
            state_nx        = FETCH;
         end
         ADDI_EX: begin
            bus.aluSrcA = 1'b1;
            bus.aluSrcB = SRCB_IMM;
            state_nx    = ADDI_WB;
         end
         ADDI_WB: begin
            bus.regWriteEnable = 1'b1;
            retire             = 1'b1;
            state_nx           = FETCH;
         end
         JUMP: begin
            bus.pcWrite  = 1'b1;
            bus.pcSource = PCSRC_JUMP;
            retire       = 1'b1;
            state_nx     = FETCH;
         end
         TRAP: begin
            bus.trap = 1'b1;
            state_nx = TRAP;
         end
         default: state_nx = FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   multicycle_control_if #(.INS_W(32), .ALU_W(5), .CNT_W(32)) bus ();

   multicycle_control #(.INS_W(32), .ALU_W(5), .CNT_W(32), .MEM_HS(1)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   typedef struct {
      string       nm;
      logic [19:0] ctl;
      logic [19:0] mask;
      logic [31:0] ret;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = 0;

   // {pcWrite,pcWriteCond,iOrD,memRead,memWrite,irWrite,regWriteEnable,regDst,memToReg,aluSrcA,aluSrcB,aluCtl,pcSource,trap}
   function automatic logic [19:0] cv(logic pw, logic pwc, logic iod, logic mrd, logic mwr,
                                      logic irw, logic rwe, logic rdst, logic m2r, logic asa,
                                      logic [1:0] asb, logic [4:0] alu, logic [1:0] pcs, logic trp);
      return {pw, pwc, iod, mrd, mwr, irw, rwe, rdst, m2r, asa, asb, alu, pcs, trp};
   endfunction

   localparam logic [19:0] E_FETCH   = cv(1,0,0,1,0,1,0,0,0,0,2'd1,5'd2,2'd0,0);
   localparam logic [19:0] E_FETCH_W = cv(0,0,0,1,0,0,0,0,0,0,2'd1,5'd2,2'd0,0);
   localparam logic [19:0] E_DECODE  = cv(0,0,0,0,0,0,0,0,0,0,2'd3,5'd2,2'd0,0);
   localparam logic [19:0] E_MEMADDR = cv(0,0,0,0,0,0,0,0,0,1,2'd2,5'd2,2'd0,0);
   localparam logic [19:0] E_MEMREAD = cv(0,0,1,1,0,0,0,0,0,0,2'd0,5'd2,2'd0,0);
   localparam logic [19:0] E_MEMWB   = cv(0,0,0,0,0,0,1,0,1,0,2'd0,5'd2,2'd0,0);
   localparam logic [19:0] E_MEMWR   = cv(0,0,1,0,1,0,0,0,0,0,2'd0,5'd2,2'd0,0);
   localparam logic [19:0] E_RTWB    = cv(0,0,0,0,0,0,1,1,0,0,2'd0,5'd2,2'd0,0);
   localparam logic [19:0] E_BRANCH  = cv(0,1,0,0,0,0,0,0,0,1,2'd0,5'd6,2'd1,0);
   localparam logic [19:0] E_ADDIEX  = cv(0,0,0,0,0,0,0,0,0,1,2'd2,5'd2,2'd0,0);
   localparam logic [19:0] E_ADDIWB  = cv(0,0,0,0,0,0,1,0,0,0,2'd0,5'd2,2'd0,0);
   localparam logic [19:0] E_JUMP    = cv(1,0,0,0,0,0,0,0,0,0,2'd0,5'd2,2'd2,0);
   localparam logic [19:0] E_TRAP    = cv(0,0,0,0,0,0,0,0,0,0,2'd0,5'd2,2'd0,1);
   localparam logic [19:0] M_ALL     = 20'hFFFFF;
   localparam logic [19:0] M_NO_ALU  = 20'hFFF07;

   localparam logic [31:0] R_WORDS [5] = '{32'h00430822, 32'h00430820, 32'h00430824,
                                            32'h00430825, 32'h0043082A};
   localparam logic [4:0]  R_ALU   [5] = '{5'd6, 5'd2, 5'd0, 5'd1, 5'd7};

   function automatic logic [19:0] e_rtex(logic [4:0] alu);
      return cv(0,0,0,0,0,0,0,0,0,1,2'd0,alu,2'd0,0);
   endfunction

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         exp_t        e;
         logic [19:0] act;
         e   = sb.pop_front();
         act = {bus.pcWrite, bus.pcWriteCond, bus.iOrD, bus.memRead, bus.memWrite,
                bus.irWrite, bus.regWriteEnable, bus.regDst, bus.memToReg, bus.aluSrcA,
                bus.aluSrcB, bus.aluCtl, bus.pcSource, bus.trap};
         checks++;
         if ((act & e.mask) !== (e.ctl & e.mask)) begin
            errors++;
            $display("FAIL %s ctl actual=%h required=%h", e.nm, act & e.mask, e.ctl & e.mask);
         end
         checks++;
         if (bus.retired !== e.ret) begin
            errors++;
            $display("FAIL %s retired actual=%0d required=%0d", e.nm, bus.retired, e.ret);
         end
      end
   end

   task automatic step(input string nm, input logic rdy, input logic [19:0] c,
                       input bit inc, input logic [19:0] mask);
      @(posedge clk);
      #1;
      bus.memReady = rdy;
      sb.push_back('{nm, c, mask, exp_ret});
      if (inc) exp_ret = exp_ret + 1;
   endtask

   task automatic fetch(input string nm, input logic [31:0] w, input int waits);
      bus.ins = w;
      for (int i = 0; i < waits; i++) step({nm, ".fetchwait"}, 1'b0, E_FETCH_W, 0, M_ALL);
      step({nm, ".fetch"}, 1'b1, E_FETCH, 0, M_ALL);
      step({nm, ".decode"}, 1'b1, E_DECODE, 0, M_ALL);
   endtask

   task automatic reset_now(input string nm);
      @(posedge clk);
      #1;
      rst_n        = 1'b0;
      bus.memReady = 1'b1;
      exp_ret      = 0;
      sb.push_back('{nm, E_FETCH, M_ALL, 32'd0});
      @(posedge clk);
      #7;
      bus.memReady = 1'b0;
      rst_n        = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n        = 1'b0;
      bus.memReady = 1'b1;
      bus.zero     = 1'b0;
      bus.ins      = 32'h0;
      #1;
      sb.push_back('{"reset", E_FETCH, M_ALL, 32'd0});
      @(posedge clk);
      #7;
      bus.memReady = 1'b0;
      rst_n        = 1'b1;

      fetch("lw", 32'h8C220004, 0);
      step("lw.addr", 1, E_MEMADDR, 0, M_ALL);
      step("lw.read", 1, E_MEMREAD, 0, M_ALL);
      step("lw.wb",   1, E_MEMWB,   1, M_ALL);

      fetch("sw", 32'hAC220004, 1);
      step("sw.addr", 1, E_MEMADDR, 0, M_ALL);
      for (int i = 0; i < 3; i++) step("sw.wait", 0, E_MEMWR, 0, M_ALL);
      step("sw.write", 1, E_MEMWR, 1, M_ALL);

      for (int k = 0; k < 5; k++) begin
         fetch("rtype", R_WORDS[k], 0);
         step("rtype.ex", 1, e_rtex(R_ALU[k]), 0, M_ALL);
         step("rtype.wb", 1, E_RTWB, 1, M_ALL);
      end

      fetch("addi", 32'h20220005, 0);
      step("addi.ex", 1, E_ADDIEX, 0, M_ALL);
      step("addi.wb", 1, E_ADDIWB, 1, M_ALL);

      fetch("beq", 32'h10220003, 0);
      step("beq.branch", 1, E_BRANCH, 1, M_ALL);

      fetch("j", 32'h08000010, 0);
      step("j.jump", 1, E_JUMP, 1, M_ALL);

      fetch("lw2", 32'h8C220004, 0);
      step("lw2.addr", 1, E_MEMADDR, 0, M_ALL);
      step("lw2.wait", 0, E_MEMREAD, 0, M_ALL);
      step("lw2.wait", 0, E_MEMREAD, 0, M_ALL);
      reset_now("rst.memread");

      fetch("sw2", 32'hAC220004, 0);
      step("sw2.addr", 1, E_MEMADDR, 0, M_ALL);
      step("sw2.wait", 0, E_MEMWR, 0, M_ALL);
      reset_now("rst.memwrite");

      fetch("badfn", 32'h00430827, 0);
      step("badfn.ex", 1, e_rtex(5'd2), 0, M_NO_ALU);
      for (int i = 0; i < 3; i++) step("badfn.trap", 1, E_TRAP, 0, M_ALL);
      reset_now("rst.badfn");

      fetch("addi2", 32'h20220005, 0);
      step("addi2.ex", 1, E_ADDIEX, 0, M_ALL);
      step("addi2.wb", 1, E_ADDIWB, 1, M_ALL);

      fetch("badop", 32'hFC000000, 0);
      for (int i = 0; i < 12; i++) step("badop.trap", i[0], E_TRAP, 0, M_ALL);
      reset_now("rst.trap");

      fetch("j2", 32'h08000010, 0);
      step("j2.jump", 1, E_JUMP, 1, M_ALL);
      bus.ins = 32'h0;
      step("final.fetch", 1, E_FETCH, 0, M_ALL);

      repeat (2) @(posedge clk);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard leftover actual=%0d required=0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
